ftdi_cmd_engine: RTL
====================

// Module: ftdi_cmd_engine
// PURPOSE
// Command engine between the FTDI RX FIFO (host->FPGA bytes) and the register file (RFG).
// Parses header/address/length frames from the byte stream and executes RFG write or read bursts.
// Pushes read results into the FTDI TX FIFO (FPGA->host). Runs entirely in the system clk domain.
// PARAMETERS
// AW          8      RFG address width (address byte is zero-extended/truncated to AW)
// RD_TIMEOUT  255    clk cycles to wait for rfg_read_valid before substituting ERR_BYTE
// ERR_BYTE    8'hEE  byte pushed to TX FIFO on a read timeout
// PORTS
// clk              in   1   system clock; all logic on rising edge
// res              in   1   asynchronous reset, active-high
// ri_data          in   8   RX FIFO data; valid the cycle after ri_read (standard, non-FWFT)
// ri_empty         in   1   RX FIFO empty
// ri_read          out  1   RX FIFO read enable, single-cycle pulse
// tx_data          out  8   byte to TX FIFO
// tx_wr            out  1   TX FIFO write enable; only asserted when tx_full=0
// tx_full          in   1   TX FIFO full
// rfg_address      out  AW  RFG address
// rfg_write        out  1   RFG write strobe, 1 cycle
// rfg_write_value  out  8   RFG write data
// rfg_read         out  1   RFG read strobe, 1 cycle
// rfg_read_valid   in   1   RFG read data valid (any latency >=1 cycle)
// rfg_read_value   in   8   RFG read data
// busy             out  1   high in every state except IDLE
// BEHAVIOUR
// - Frame: HDR, ADDR, LEN_H, LEN_L, then LEN data bytes if write. HDR[0]=1 write, 0 read;
//   HDR[1]=1 auto-increment address per byte, 0 fixed address; HDR[7:2] ignored.
// - Reset: all outputs 0, state IDLE, counters/registers cleared. Reset mid-frame discards frame.
// - Byte fetch: ri_read pulses only when ri_empty=0; byte captured exactly 1 cycle later;
//   no second ri_read until the previous byte is captured (max 1 byte per 2 clk).
// - FSM: IDLE -> F_HDR -> F_ADDR -> F_LENH -> F_LENL -> (LEN=0: IDLE)
//   write: WR_FETCH -> WR_EXEC (rfg_write=1 one cycle) -> WR_FETCH or IDLE when count hits 0
//   read:  RD_REQ (rfg_read=1 one cycle) -> RD_WAIT -> RD_PUSH -> RD_REQ or IDLE when count 0.
// - Counter: 16-bit remaining-bytes, loaded with {LEN_H,LEN_L}, decremented per completed byte.
// - Address: AW-bit register; increments after each RFG access when auto-inc; wraps max->0.
// - RD_WAIT: captures rfg_read_value when rfg_read_valid=1; if RD_TIMEOUT cycles elapse first,
//   captures ERR_BYTE. rfg_read_valid outside RD_WAIT is ignored.
// - RD_PUSH: holds byte; asserts tx_wr for exactly 1 cycle in the first cycle tx_full=0. No bytes lost.
// - Read strobe to next read strobe: >=3 clk. Write byte: ri_read to rfg_write = 2 clk.
// - RX stall (ri_empty) in any fetch state: wait indefinitely, outputs idle, no timeout.
// - tx_wr and ri_read may assert in the same cycle only never (engine is single-phase).
// TESTING
// 1 Write: bytes 01,10,00,03,AA,BB,CC -> rfg_write at addr 10,10,10 with AA,BB,CC; busy low after.
// 2 Auto-inc read: 02,FE,00,03, rfg returns 11,22,33 -> reads at FE,FF,00 (wrap); tx bytes 11,22,33.
// 3 Backpressure: read LEN=2 with tx_full high 20 cycles on 1st push -> tx_wr once per byte, order kept.
// 4 Timeout: read LEN=1, rfg_read_valid never asserted -> after 255 clk tx byte EE, return IDLE.
// 5 Zero length/stall: 01,20,00,00 then ri_empty gaps mid-header -> no RFG strobe, no ri_read while empty.
// 6 Reset mid-write after 1 of 3 data bytes -> outputs 0, IDLE; next frame 01,05,00,01,5A writes 5A@05.

Source files
------------

// File: rtl/ftdi_cmd_engine_if.sv
// Bus bundle for the FTDI command engine: RX FIFO read side, TX FIFO write side and RFG access.
// The engine uses the master modport; FIFO and register-file models use the slave modport.
interface ftdi_cmd_engine_if #(
   parameter int unsigned AW = 8
);
   logic [7:0]    ri_data;
   logic          ri_empty;
   logic          ri_read;
   logic [7:0]    tx_data;
   logic          tx_wr;
   logic          tx_full;
   logic [AW-1:0] rfg_address;
   logic          rfg_write;
   logic [7:0]    rfg_write_value;
   logic          rfg_read;
   logic          rfg_read_valid;
   logic [7:0]    rfg_read_value;

   modport master (
      input  ri_data, ri_empty, tx_full, rfg_read_valid, rfg_read_value,
      output ri_read, tx_data, tx_wr, rfg_address, rfg_write, rfg_write_value, rfg_read
   );

   modport slave (
      output ri_data, ri_empty, tx_full, rfg_read_valid, rfg_read_value,
      input  ri_read, tx_data, tx_wr, rfg_address, rfg_write, rfg_write_value, rfg_read
   );
endinterface

// File: rtl/ftdi_cmd_engine.sv
// Frame parser between the FTDI RX FIFO and the register file.
// It executes write or read bursts and pushes the read results into the FTDI TX FIFO.
module ftdi_cmd_engine #(
   parameter int unsigned AW         = 8,
   parameter int unsigned RD_TIMEOUT = 255,
   parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
   input  logic              clk,
   input  logic              res,
   ftdi_cmd_engine_if.master bus,
   output logic              busy
);
   localparam int unsigned CW = 16;
   localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, F_HDR, F_ADDR, F_LENH, F_LENL, WR_FETCH, WR_EXEC, RD_REQ, RD_WAIT, RD_PUSH
   } state_t;

   state_t        state, state_d;
   logic          pending, pending_d;
   logic          is_write, is_write_d;
   logic          auto_inc, auto_inc_d;
   logic [AW-1:0] addr, addr_d;
   logic [CW-1:0] count, count_d;
   logic [TW-1:0] timer, timer_d;
   logic [7:0]    wr_val, wr_val_d;
   logic [7:0]    rd_val, rd_val_d;
   logic          rfg_write_d, rfg_read_d, busy_d;
   logic          fetch, byte_ok;

   assign bus.rfg_address     = addr;
   assign bus.rfg_write_value = wr_val;
   assign bus.tx_data         = rd_val;

   // State and datapath registers
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state         <= IDLE;
         pending       <= 1'b0;
         is_write      <= 1'b0;
         auto_inc      <= 1'b0;
         addr          <= '0;
         count         <= '0;
         timer         <= '0;
         wr_val        <= '0;
         rd_val        <= '0;
         bus.rfg_write <= 1'b0;
         bus.rfg_read  <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_d;
         pending       <= pending_d;
         is_write      <= is_write_d;
         auto_inc      <= auto_inc_d;
         addr          <= addr_d;
         count         <= count_d;
         timer         <= timer_d;
         wr_val        <= wr_val_d;
         rd_val        <= rd_val_d;
         bus.rfg_write <= rfg_write_d;
         bus.rfg_read  <= rfg_read_d;
         busy          <= busy_d;
      end
   end

   // Next state; ri_read and tx_wr follow the live FIFO flags so they never hit an empty/full FIFO
   always_comb begin
      state_d     = state;
      pending_d   = pending;
      is_write_d  = is_write;
      auto_inc_d  = auto_inc;
      addr_d      = addr;
      count_d     = count;
      timer_d     = timer;
      wr_val_d    = wr_val;
      rd_val_d    = rd_val;
      bus.ri_read = 1'b0;
      bus.tx_wr   = 1'b0;
      byte_ok     = 1'b0;

      fetch = (state == F_HDR) || (state == F_ADDR) || (state == F_LENH) ||
              (state == F_LENL) || (state == WR_FETCH);

      // Non-FWFT FIFO: the byte requested in one cycle is taken in the next
      if (fetch) begin
         if (pending) begin
            pending_d = 1'b0;
            byte_ok   = 1'b1;
         end else if (!bus.ri_empty) begin
            bus.ri_read = 1'b1;
            pending_d   = 1'b1;
         end
      end

      case (state)
         IDLE: if (!bus.ri_empty) state_d = F_HDR;
         F_HDR: if (byte_ok) begin
            is_write_d = bus.ri_data[0];
            auto_inc_d = bus.ri_data[1];
            state_d    = F_ADDR;
         end
         F_ADDR: if (byte_ok) begin
            addr_d  = AW'(bus.ri_data);
            state_d = F_LENH;
         end
         F_LENH: if (byte_ok) begin
            count_d = {bus.ri_data, 8'h00};
            state_d = F_LENL;
         end
         F_LENL: if (byte_ok) begin
            count_d = {count[15:8], bus.ri_data};
            if (count_d == '0)  state_d = IDLE;
            else if (is_write)  state_d = WR_FETCH;
            else                state_d = RD_REQ;
         end
         WR_FETCH: if (byte_ok) begin
            wr_val_d = bus.ri_data;
            state_d  = WR_EXEC;
         end
         WR_EXEC: begin
            count_d = count - CW'(1);
            if (auto_inc) addr_d = addr + AW'(1);
            state_d = (count == CW'(1)) ? IDLE : WR_FETCH;
         end
         RD_REQ: begin
            timer_d = '0;
            state_d = RD_WAIT;
         end
         // A late valid on the last timeout cycle still wins over the error byte
         RD_WAIT: begin
            if (bus.rfg_read_valid || (timer == TW'(RD_TIMEOUT - 1))) begin
               rd_val_d = bus.rfg_read_valid ? bus.rfg_read_value : ERR_BYTE;
               if (auto_inc) addr_d = addr + AW'(1);
               state_d  = RD_PUSH;
            end else begin
               timer_d = timer + TW'(1);
            end
         end
         RD_PUSH: if (!bus.tx_full) begin
            bus.tx_wr = 1'b1;
            count_d   = count - CW'(1);
            state_d   = (count == CW'(1)) ? IDLE : RD_REQ;
         end
         default: state_d = IDLE;
      endcase

      rfg_write_d = (state_d == WR_EXEC);
      rfg_read_d  = (state_d == RD_REQ);
      busy_d      = (state_d != IDLE);
   end
endmodule
